// File: rtl/core_pkg.sv
// Shared core definitions: memory access sizes and arbiter encodings.
package core_pkg;

    // Access size carried on the ByteEn buses.
    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    // Arbiter FSM state.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Which requester owns the in-flight transaction.
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, controller and halt signals around mem_arbiter.
// slave: the arbiter side; master: the surrounding core/controller side.
interface mem_arbiter_if;
    logic        Halt;
    logic        Halted;
    logic        Busy;

    logic        F_Req;
    logic [31:0] F_Addr;
    logic        F_Ack;
    logic        F_Valid;
    logic [31:0] F_RData;

    logic        D_Req;
    logic        D_We;
    logic [31:0] D_Addr;
    logic [31:0] D_WData;
    logic [1:0]  D_ByteEn;
    logic        D_SignExtend;
    logic        D_Ack;
    logic        D_Valid;
    logic [31:0] D_RData;

    logic        MC_Ready;
    logic        MC_Execute;
    logic        MC_We;
    logic [31:0] MC_Addr;
    logic [31:0] MC_InData;
    logic [1:0]  MC_ByteEn;
    logic        MC_SignExtend;
    logic [31:0] MC_OutData;
    logic        MC_DataReady;

    modport slave (
        input  Halt, F_Req, F_Addr,
        input  D_Req, D_We, D_Addr, D_WData, D_ByteEn, D_SignExtend,
        input  MC_Ready, MC_OutData, MC_DataReady,
        output Halted, Busy, F_Ack, F_Valid, F_RData, D_Ack, D_Valid, D_RData,
        output MC_Execute, MC_We, MC_Addr, MC_InData, MC_ByteEn, MC_SignExtend
    );

    modport master (
        output Halt, F_Req, F_Addr,
        output D_Req, D_We, D_Addr, D_WData, D_ByteEn, D_SignExtend,
        output MC_Ready, MC_OutData, MC_DataReady,
        input  Halted, Busy, F_Ack, F_Valid, F_RData, D_Ack, D_Valid, D_RData,
        input  MC_Execute, MC_We, MC_Addr, MC_InData, MC_ByteEn, MC_SignExtend
    );
endinterface

// File: rtl/mem_arb_select.sv
// Winner pick between fetch and data plus the fetch starvation counter.
module mem_arb_select
    import core_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_f_req,
    input  logic       i_d_req,
    input  logic       i_grant,
    output arb_owner_t o_winner
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_count;
    logic             w_starved;

    assign w_starved = (r_count == CNT_W'(STARVE_LIMIT));

    // Data wins unless fetch is also waiting and has hit its starvation limit.
    always_comb begin
        // NOTE: default first so every path assigns o_winner and no latch is inferred.
        o_winner = OWN_FETCH;
        if (i_d_req && !(i_f_req && w_starved)) begin
            o_winner = OWN_DATA;
        end
    end

    // Count data grants that passed over a waiting fetch; any fetch grant clears it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_grant) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            if (o_winner == OWN_FETCH) begin
                r_count <= '0;
            end else if (i_f_req && !w_starved) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing the memory controller port between
// instruction fetch and load/store, with a halt gate on new grants.
module mem_arbiter
    import core_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    mem_arbiter_if.slave  bus
);
    arb_state_t r_state;
    arb_state_t w_next_state;
    arb_owner_t r_owner;
    arb_owner_t w_winner;
    logic       w_grant;
    logic       w_complete;

    logic        r_mc_execute;
    logic        r_mc_we;
    logic [31:0] r_mc_addr;
    logic [31:0] r_mc_indata;
    logic [1:0]  r_mc_byteen;
    logic        r_mc_signext;
    logic        r_f_ack;
    logic        r_d_ack;
    logic        r_f_valid;
    logic        r_d_valid;
    logic [31:0] r_f_rdata;
    logic [31:0] r_d_rdata;
    logic        r_halted;

    mem_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .i_clk    (Clk),
        .i_rst    (Reset),
        .i_f_req  (bus.F_Req),
        .i_d_req  (bus.D_Req),
        .i_grant  (w_grant),
        .o_winner (w_winner)
    );

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: grant from IDLE when allowed, return to IDLE on completion.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (!bus.Halt && bus.MC_Ready && (bus.F_Req || bus.D_Req)) begin
                    w_grant      = 1'b1;
                    w_next_state = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (bus.MC_DataReady) begin
                    w_complete   = 1'b1;
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // Command/response registers: latch the winner on grant, route data on completion.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_owner      <= OWN_FETCH;
            r_mc_execute <= 1'b0;
            r_mc_we      <= 1'b0;
            r_mc_addr    <= '0;
            r_mc_indata  <= '0;
            r_mc_byteen  <= '0;
            r_mc_signext <= 1'b0;
            r_f_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_f_valid    <= 1'b0;
            r_d_valid    <= 1'b0;
            r_f_rdata    <= '0;
            r_d_rdata    <= '0;
            r_halted     <= 1'b0;
        end else begin
            r_mc_execute <= 1'b0;
            r_f_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_f_valid    <= 1'b0;
            r_d_valid    <= 1'b0;
            r_halted     <= (r_state == ARB_IDLE) && bus.Halt;

            if (w_grant) begin
                r_mc_execute <= 1'b1;
                r_owner      <= w_winner;
                if (w_winner == OWN_DATA) begin
                    r_d_ack      <= 1'b1;
                    r_mc_we      <= bus.D_We;
                    r_mc_addr    <= bus.D_Addr;
                    r_mc_indata  <= bus.D_WData;
                    r_mc_byteen  <= bus.D_ByteEn;
                    r_mc_signext <= bus.D_SignExtend;
                end else begin
                    r_f_ack      <= 1'b1;
                    r_mc_we      <= 1'b0;
                    r_mc_addr    <= bus.F_Addr;
                    r_mc_indata  <= '0;
                    r_mc_byteen  <= MEM_WORD;
                    r_mc_signext <= 1'b0;
                end
            end

            if (w_complete) begin
                if (r_owner == OWN_FETCH) begin
                    r_f_valid <= 1'b1;
                    r_f_rdata <= bus.MC_OutData;
                end else begin
                    r_d_valid <= 1'b1;
                    r_d_rdata <= r_mc_we ? '0 : bus.MC_OutData;
                end
            end
        end
    end

    assign bus.Busy          = (r_state != ARB_IDLE);
    assign bus.Halted        = r_halted;
    assign bus.F_Ack         = r_f_ack;
    assign bus.F_Valid       = r_f_valid;
    assign bus.F_RData       = r_f_rdata;
    assign bus.D_Ack         = r_d_ack;
    assign bus.D_Valid       = r_d_valid;
    assign bus.D_RData       = r_d_rdata;
    assign bus.MC_Execute    = r_mc_execute;
    assign bus.MC_We         = r_mc_we;
    assign bus.MC_Addr       = r_mc_addr;
    assign bus.MC_InData     = r_mc_indata;
    assign bus.MC_ByteEn     = r_mc_byteen;
    assign bus.MC_SignExtend = r_mc_signext;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected grants and
// responses; a negedge monitor pops and compares whenever the DUT pulses.
module tb_mem_arbiter;
    import core_pkg::*;

    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  be;
        bit          sx;
        int          cyc;
    } grant_t;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    logic Clk;
    logic Reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_exec = 0;

    grant_t exp_grant_q[$];
    resp_t  exp_resp_q[$];
    grant_t mon_g;
    resp_t  mon_r;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_LIMIT (4)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [159:0] outs();
        return {21'd0, bus.F_Ack, bus.F_Valid, bus.F_RData, bus.D_Ack, bus.D_Valid,
                bus.D_RData, bus.MC_Execute, bus.MC_We, bus.MC_Addr, bus.MC_InData,
                bus.MC_ByteEn, bus.MC_SignExtend, bus.Halted, bus.Busy};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic push_grant(input bit is_data, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] be, input bit sx);
        grant_t g;
        g.is_data = is_data; g.we = we; g.addr = addr; g.wdata = wdata;
        g.be = be; g.sx = sx; g.cyc = cyc + 1;
        exp_grant_q.push_back(g);
    endtask

    task automatic push_resp(input bit is_data, input logic [31:0] rdata);
        resp_t r;
        r.is_data = is_data; r.rdata = rdata; r.cyc = cyc + 1;
        exp_resp_q.push_back(r);
    endtask

    // One uncontended transaction; for fetch the we/wdata/be/sx arguments are
    // the hand-written MC values expected, only addr is driven.
    task automatic run_txn(input bit is_data, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] be, input bit sx,
                           input logic [31:0] mc_data, input logic [31:0] exp_rdata,
                           input int lat);
        if (is_data) begin
            bus.D_Req = 1'b1; bus.D_We = we; bus.D_Addr = addr;
            bus.D_WData = wdata; bus.D_ByteEn = be; bus.D_SignExtend = sx;
        end else begin
            bus.F_Req = 1'b1; bus.F_Addr = addr;
        end
        push_grant(is_data, we, addr, wdata, be, sx);
        tick(1);
        bus.F_Req = 1'b0;
        bus.D_Req = 1'b0;
        check("busy_in_txn", bus.Busy, 1);
        tick(lat);
        bus.MC_DataReady = 1'b1;
        bus.MC_OutData   = mc_data;
        push_resp(is_data, exp_rdata);
        tick(1);
        bus.MC_DataReady = 1'b0;
        check("idle_after_valid", bus.Busy, 0);
    endtask

    // Monitor: every Execute / Valid pulse must match the head of its queue.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (bus.MC_Execute) begin
                n_exec++;
                if (exp_grant_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_execute: got execute at cycle %0d, expected none", cyc);
                end else begin
                    mon_g = exp_grant_q.pop_front();
                    check("grant_fields",
                          {88'd0, bus.F_Ack, bus.D_Ack, bus.MC_We, bus.MC_ByteEn,
                           bus.MC_SignExtend, bus.MC_Addr, bus.MC_InData},
                          {88'd0, ~mon_g.is_data, mon_g.is_data, mon_g.we, mon_g.be,
                           mon_g.sx, mon_g.addr, mon_g.wdata});
                    check("grant_cycle", cyc, mon_g.cyc);
                end
            end else if (bus.F_Ack || bus.D_Ack) begin
                n_cmp++; n_err++;
                $display("FAIL stray_ack: got F_Ack=%0b D_Ack=%0b without execute, expected 0", bus.F_Ack, bus.D_Ack);
            end
            if (bus.F_Valid || bus.D_Valid) begin
                if (exp_resp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_valid: got F_Valid=%0b D_Valid=%0b at cycle %0d, expected none",
                             bus.F_Valid, bus.D_Valid, cyc);
                end else begin
                    mon_r = exp_resp_q.pop_front();
                    check("resp_data",
                          {126'd0, bus.F_Valid, bus.D_Valid, mon_r.is_data ? bus.D_RData : bus.F_RData},
                          {126'd0, ~mon_r.is_data, mon_r.is_data, mon_r.rdata});
                    check("resp_cycle", cyc, mon_r.cyc);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 50000ns");
        $fatal(1);
    end

    initial begin
        int n0;
        bus.Halt = 0; bus.F_Req = 0; bus.F_Addr = 0;
        bus.D_Req = 0; bus.D_We = 0; bus.D_Addr = 0; bus.D_WData = 0;
        bus.D_ByteEn = 0; bus.D_SignExtend = 0;
        bus.MC_Ready = 0; bus.MC_OutData = 0; bus.MC_DataReady = 0;
        Reset = 1'b1;
        #3;
        check("reset_outputs", outs(), 0);
        tick(2);
        Reset = 1'b0;
        tick(2);

        // Fetch-only read, controller answers three cycles after Execute.
        bus.MC_Ready = 1'b1;
        run_txn(0, 0, 32'h0000_0100, 32'h0, MEM_WORD, 0, 32'h0050_0093, 32'h0050_0093, 3);
        tick(1);

        // Half-word store: read data forced to 0.
        run_txn(1, 1, 32'h0000_2000, 32'hDEAD_BEEF, MEM_HALF, 0, 32'h1234_5678, 32'h0, 2);

        // Sign-extended byte load, back-to-back with the store.
        run_txn(1, 0, 32'h0000_2004, 32'h0, MEM_BYTE, 1, 32'hFFFF_FF80, 32'hFFFF_FF80, 1);

        // Contention: both requests held; expect D,D,D,D,F,D,D,D,D,F.
        bus.F_Addr = 32'h0000_0200;
        bus.D_We = 0; bus.D_Addr = 32'h0000_3000; bus.D_WData = 0;
        bus.D_ByteEn = MEM_HALF; bus.D_SignExtend = 1;
        bus.F_Req = 1; bus.D_Req = 1;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) push_grant(0, 0, 32'h0000_0200, 32'h0, MEM_WORD, 0);
            else            push_grant(1, 0, 32'h0000_3000, 32'h0, MEM_HALF, 1);
            tick(2);
            bus.MC_DataReady = 1;
            bus.MC_OutData   = 32'h1000 + i;
            push_resp(i % 5 != 4, 32'h1000 + i);
            tick(1);
            bus.MC_DataReady = 0;
        end
        bus.F_Req = 0; bus.D_Req = 0;
        tick(2);

        // Halt raised while busy; pending fetch waits until Halt drops.
        bus.D_Req = 1; bus.D_We = 0; bus.D_Addr = 32'h40; bus.D_WData = 0;
        bus.D_ByteEn = MEM_WORD; bus.D_SignExtend = 0;
        push_grant(1, 0, 32'h40, 32'h0, MEM_WORD, 0);
        tick(1);
        bus.D_Req = 0; bus.Halt = 1; bus.F_Req = 1; bus.F_Addr = 32'h0000_0300;
        tick(2);
        bus.MC_DataReady = 1; bus.MC_OutData = 32'hCAFE_F00D;
        push_resp(1, 32'hCAFE_F00D);
        tick(1);
        bus.MC_DataReady = 0;
        check("halted_low_entering_idle", bus.Halted, 0);
        n0 = n_exec;
        tick(1);
        check("halted_after_idle", bus.Halted, 1);
        tick(4);
        check("no_exec_while_halted", n_exec, n0);
        check("halted_held", bus.Halted, 1);
        bus.Halt = 0;
        push_grant(0, 0, 32'h0000_0300, 32'h0, MEM_WORD, 0);
        tick(1);
        check("halted_falls", bus.Halted, 0);
        bus.F_Req = 0;
        tick(2);
        bus.MC_DataReady = 1; bus.MC_OutData = 32'h0000_0013;
        push_resp(0, 32'h0000_0013);
        tick(1);
        bus.MC_DataReady = 0;
        tick(1);

        // Controller not ready for 5 cycles with a data request pending.
        bus.MC_Ready = 0;
        bus.D_Req = 1; bus.D_We = 1; bus.D_Addr = 32'h5000; bus.D_WData = 32'hA5A5_A5A5;
        bus.D_ByteEn = MEM_BYTE; bus.D_SignExtend = 0;
        n0 = n_exec;
        tick(5);
        check("no_exec_while_not_ready", n_exec, n0);
        check("no_dack_while_not_ready", bus.D_Ack, 0);
        bus.MC_Ready = 1;
        push_grant(1, 1, 32'h5000, 32'hA5A5_A5A5, MEM_BYTE, 0);
        tick(1);
        bus.D_Req = 0;
        tick(2);
        bus.MC_DataReady = 1; bus.MC_OutData = 32'h7777_7777;
        push_resp(1, 32'h0);
        tick(1);
        bus.MC_DataReady = 0;
        tick(1);

        // Reset mid-BUSY: transaction abandoned, late DataReady ignored.
        bus.D_Req = 1; bus.D_We = 1; bus.D_Addr = 32'h4000; bus.D_WData = 32'h1122_3344;
        bus.D_ByteEn = MEM_WORD; bus.D_SignExtend = 0;
        push_grant(1, 1, 32'h4000, 32'h1122_3344, MEM_WORD, 0);
        tick(1);
        bus.D_Req = 0;
        tick(1);
        check("busy_before_reset", bus.Busy, 1);
        Reset = 1;
        #1;
        check("outputs_in_reset", outs(), 0);
        tick(1);
        Reset = 0;
        bus.MC_DataReady = 1; bus.MC_OutData = 32'h0000_0099;
        tick(1);
        bus.MC_DataReady = 0;
        check("idle_after_reset", bus.Busy, 0);
        tick(3);

        check("grant_queue_drained", exp_grant_q.size(), 0);
        check("resp_queue_drained", exp_resp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single `mem_controller` request port between the instruction-fetch path and the load/store path. It accepts at most one transaction at a time and gives data accesses priority, with a starvation limit that protects fetch. It drives the controller's Execute/We/Address/InData/DataByteEn/SignExtend inputs and routes OutData/DataReady back to the winning requester. It sits between `pc`/decode/`alu` and `mem_controller`, and supplies the `Halted` indication for the core.

## Interface
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch is waiting; the next contended grant then goes to fetch (≥1).
- `Clk` in 1: core clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-high.
- `Halt` in 1: stop issuing new grants.
- `Halted` out 1: registered; 1 when idle and `Halt` is high.
- `F_Req` in 1: fetch request; must be held until `F_Ack`.
- `F_Addr` in 32: fetch address.
- `F_Ack` out 1: one-cycle pulse; fetch request accepted.
- `F_Valid` out 1: one-cycle pulse; `F_RData` is valid.
- `F_RData` out 32: instruction word.
- `D_Req` in 1: load/store request; must be held until `D_Ack`.
- `D_We` in 1: 1 for a store.
- `D_Addr` in 32: data address.
- `D_WData` in 32: store data.
- `D_ByteEn` in 2: access size; 00 byte, 01 half, 10 word.
- `D_SignExtend` in 1: sign-extend loaded data.
- `D_Ack` out 1: one-cycle pulse; data request accepted.
- `D_Valid` out 1: one-cycle pulse; load data valid or store complete.
- `D_RData` out 32: load data; 0 for stores.
- `MC_Ready` in 1: controller can accept a command.
- `MC_Execute` out 1: one-cycle command strobe.
- `MC_We` out 1: write enable.
- `MC_Addr` out 32: address.
- `MC_InData` out 32: write data.
- `MC_ByteEn` out 2: access size.
- `MC_SignExtend` out 1: sign-extend flag.
- `MC_OutData` in 32: read data from the controller.
- `MC_DataReady` in 1: one-cycle completion pulse; fires for both reads and writes.
- `Busy` out 1: 1 whenever the state is not IDLE.

## Operation
- **States:** IDLE, BUSY. Owner register records the winner (FETCH or DATA).
- **IDLE → BUSY:** when `!Halt && MC_Ready && (F_Req || D_Req)`.
  - Latch the winner's fields into the MC_* registers.
  - Pulse `MC_Execute` and the winner's Ack.
- **Winner selection:**
  - Only one request pending: that requester wins.
  - Both pending: DATA wins, unless the starvation counter equals `STARVE_LIMIT`; then FETCH wins.
- **Fetch fields:** `MC_We`=0, `MC_ByteEn`=10, `MC_SignExtend`=0, `MC_InData`=0.
- **Starvation counter** (width `$clog2(STARVE_LIMIT+1)`):
  - Increments on a DATA grant made while `F_Req` is high.
  - Clears on any FETCH grant.
  - Saturates at `STARVE_LIMIT`.
- **BUSY → IDLE:** on `MC_DataReady`.
  - Register `MC_OutData` into the owner's RData (DATA store: 0).
  - Pulse the owner's Valid.
- `MC_DataReady` while in IDLE is ignored.
- **Halt:**
  - Sampled only in IDLE.
  - An in-flight transaction always completes.
  - `Halted` rises the cycle after IDLE and `Halt` are both true, and falls the cycle after `Halt` drops.
- **Reset:** all outputs and registers return to 0, state to IDLE, counter to 0.
  - Reset mid-BUSY abandons the transaction; no Valid is produced for it.

## Timing
- Request seen in IDLE at edge N → `MC_Execute`, Ack and MC_* fields valid in cycle N+1; state is BUSY in N+1.
- `MC_*` fields hold their values until the next grant.
- `MC_DataReady` at edge M → Valid and RData in cycle M+1; state is IDLE in M+1.
- Earliest next `MC_Execute` is cycle M+2.
- Ack and Valid are exact one-cycle pulses and are never asserted to both requesters in the same cycle.
- A requester may drop or change its request in the cycle after its Ack. The arbiter is in BUSY then, so no double grant can occur.
- Req asserted while `MC_Ready`=0 waits in IDLE with no Ack.

## Structure
- **Shared `core_pkg`:**
  - Byte-enable encodings MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10.
  - Arbiter state encoding (IDLE, BUSY).
  - Owner encoding (FETCH, DATA).
- **Sub-module `mem_arb_select`:** combinational winner pick plus the starvation counter register. Everything else stays in `mem_arbiter`.

## Test plan
- **Fetch-only read:** `F_Req`, `F_Addr`=0x100, `MC_Ready`=1; controller returns 0x00500093 three cycles after Execute.
  - `MC_Execute` with `MC_ByteEn`=10, `MC_We`=0 in cycle N+1.
  - `F_Valid` with `F_RData`=0x00500093 one cycle after `MC_DataReady`.
- **Store:** `D_Req`, `D_We`=1, `D_Addr`=0x2000, `D_WData`=0xDEADBEEF, `D_ByteEn`=01.
  - MC_* carry exactly those values.
  - `D_Valid` pulses with `D_RData`=0; `F_Ack` stays 0.
- **Contention:** `F_Req` and `D_Req` held continuously, `STARVE_LIMIT`=4.
  - Grant order is D, D, D, D, F, D, D, D, D, F.
- **Halt:** `Halt` raised during BUSY.
  - The transaction completes.
  - No further `MC_Execute`.
  - `Halted`=1 one cycle after IDLE.
  - Drop `Halt` → the pending `F_Req` is granted.
- **Reset mid-BUSY:** assert `Reset` for 1 cycle, then send `MC_DataReady`.
  - All outputs are 0 during reset.
  - No Valid pulse afterwards; state is IDLE.
- **Not ready:** `MC_Ready`=0 for 5 cycles with `D_Req` high.
  - No Ack and no Execute during those cycles.
  - Grant in the cycle after `MC_Ready` rises.
